mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the 5-stage RV32I pipeline: it consumes the EX/MEM register outputs, performs loads and stores over a req/gnt/rvalid data bus, and owns the MEM/WB pipeline register. It generates byte enables and store-data lane replication, extracts and extends load data, and detects misaligned accesses. It stalls the upstream pipeline until the bus transaction completes.

## Interface
- No parameters.
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- mem_pc, mem_alu_result, mem_rs2_val_for_store, mem_wb_candidate  in  32 each  from EX/MEM; alu_result is the effective address
- mem_rd_addr  in  5; mem_reg_write, mem_mem_read, mem_mem_write, mem_load_signed, mem_csr_hit, mem_ecall, mem_ebreak, mem_fence  in  1 each
- mem_wb_sel, mem_load_size, mem_store_size  in  2 each; mem_csr_addr  in  12
- stall_o  out  1  freezes PC, IF/ID, ID/EX and EX/MEM while high
- dbus_req, dbus_we  out  1; dbus_addr  out  32 (word-aligned); dbus_be  out  4; dbus_wdata  out  32
- dbus_gnt, dbus_rvalid  in  1; dbus_rdata  in  32
- wb_pc, wb_data  out  32; wb_rd_addr  out  5; wb_csr_addr  out  12
- wb_reg_write, wb_csr_hit, wb_ecall, wb_ebreak, wb_fence, wb_misaligned  out  1 each; wb_bad_addr  out  32

## Operation
- Size encoding: 00 byte, 01 half, 10 word, 11 illegal, which is treated as misaligned.
- Misaligned: half with addr[0]=1, or word with addr[1:0]≠0. If both mem_read and mem_write are high, mem_read wins and the op is a load.
- memop = (mem_read|mem_write) & aligned.
- Store lanes:
  - byte: be=4'b0001<<addr[1:0], wdata={4{rs2[7:0]}}
  - half: be=4'b0011<<{addr[1],1'b0}, wdata={2{rs2[15:0]}}
  - word: be=4'b1111, wdata=rs2
  - Loads drive be per the same rule, with we=0.
- Load extract: byte lane selected by addr[1:0], half lane by addr[1]. Sign-extend if load_signed, else zero-extend.
- wb_data mux on wb_sel: 0 = alu_result; 1 = extracted load data; 2 and 3 = wb_candidate.
- FSM states IDLE, REQ, RESP, DONE:
  - IDLE: if memop, latch dbus_addr={addr[31:2],2'b00}, be, wdata, we, then go to REQ. Otherwise stay in IDLE.
  - REQ: dbus_req=1 with addr/be/wdata/we held stable. On gnt, a store goes to DONE and a load goes to RESP.
  - RESP: on rvalid, latch dbus_rdata into the load buffer and go to DONE.
  - DONE: go to IDLE.
- stall_o = (state==IDLE & memop) | state==REQ | state==RESP. It is 0 in DONE and is forced 0 during rst.
- MEM/WB register, clocked every cycle:
  - stall_o=0: captures the current instruction.
  - stall_o=1: captures a bubble, with wb_reg_write, wb_csr_hit, wb_ecall, wb_ebreak, wb_fence and wb_misaligned all 0.
- Misaligned op (mem_read or mem_write high but not aligned):
  - No bus access and no stall.
  - Captured with wb_reg_write=0, wb_misaligned=1 and wb_bad_addr=mem_alu_result, for one cycle.
- Non-memory ops pass straight through in 1 cycle.

## Timing
- Reset (async): state=IDLE. All wb_* outputs, dbus_* outputs and the load buffer are 0.
- Reset during REQ/RESP abandons the transaction: dbus_req drops immediately and the bus must tolerate a dropped request. stall_o is 0 while rst is high.
- Bus rules:
  - dbus_req stays high until the gnt cycle and drops the cycle after gnt.
  - rvalid arrives at least one cycle after gnt. rvalid outside RESP is ignored.
- Latency from the instruction presented in EX/MEM to the MEM/WB capture edge:
  - non-mem or misaligned: 1 cycle
  - store: 3 + (gnt wait) cycles
  - load: 4 + (gnt wait) + (rvalid wait − 1) cycles
- Stall length:
  - store: stall_o high for 2 + gnt wait cycles
  - load: stall_o high for 3 cycles at minimum
- EX/MEM inputs are stable while stall_o=1. The next instruction appears the cycle after DONE.
- Back-to-back memops: DONE → IDLE → REQ gives a 1-cycle IDLE stall per op. No overlap of transactions.

## Test plan
- LW, addr 0x100, gnt in the first REQ cycle, rvalid 1 cycle later with rdata=0xDEADBEEF:
  - dbus_addr=0x100, be=1111.
  - stall_o high for 3 cycles.
  - Next edge after DONE: wb_data=0xDEADBEEF, wb_reg_write=1.
- LB, addr 0x103, rdata=0x80FF_FF7F:
  - load_signed=1 → wb_data=0xFFFF_FF80.
  - LBU, same address and rdata → 0x0000_0080.
  - LH, addr 0x102, signed, same rdata → 0xFFFF_80FF.
- SH, addr 0x206, rs2=0x1234_ABCD, gnt delayed 3 cycles:
  - dbus_req held 4 cycles with be=1100, wdata=0xABCD_ABCD, we=1.
  - wb_reg_write=0, and MEM/WB shows bubbles during the stall.
- LW at 0x102:
  - No dbus_req and no stall.
  - wb_misaligned=1, wb_bad_addr=0x102, wb_reg_write=0 for 1 cycle.
- ADD with wb_sel=0, alu=0x55, followed by JAL with wb_sel=2, cand=0x1004:
  - wb_data=0x55 then 0x1004 on consecutive cycles.
  - stall_o stays 0.
- Assert rst while in RESP:
  - dbus_req, stall_o and all wb_* go to 0 asynchronously; FSM returns to IDLE.
  - A later rvalid is ignored.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access stage of the RV32I pipeline: runs loads and stores over the req/gnt/rvalid
// data bus and holds the MEM/WB pipeline register.
module mem_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] mem_pc,
   input  logic [31:0] mem_alu_result,
   input  logic [31:0] mem_rs2_val_for_store,
   input  logic [31:0] mem_wb_candidate,
   input  logic [4:0]  mem_rd_addr,
   input  logic        mem_reg_write,
   input  logic        mem_mem_read,
   input  logic        mem_mem_write,
   input  logic        mem_load_signed,
   input  logic        mem_csr_hit,
   input  logic        mem_ecall,
   input  logic        mem_ebreak,
   input  logic        mem_fence,
   input  logic [1:0]  mem_wb_sel,
   input  logic [1:0]  mem_load_size,
   input  logic [1:0]  mem_store_size,
   input  logic [11:0] mem_csr_addr,
   output logic        stall_o,
   output logic        dbus_req,
   output logic        dbus_we,
   output logic [31:0] dbus_addr,
   output logic [3:0]  dbus_be,
   output logic [31:0] dbus_wdata,
   input  logic        dbus_gnt,
   input  logic        dbus_rvalid,
   input  logic [31:0] dbus_rdata,
   output logic [31:0] wb_pc,
   output logic [31:0] wb_data,
   output logic [4:0]  wb_rd_addr,
   output logic [11:0] wb_csr_addr,
   output logic        wb_reg_write,
   output logic        wb_csr_hit,
   output logic        wb_ecall,
   output logic        wb_ebreak,
   output logic        wb_fence,
   output logic        wb_misaligned,
   output logic [31:0] wb_bad_addr
);
   typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;
   state_t state, state_nx;

   logic [1:0]  a;
   logic [1:0]  size;
   logic        aligned, access, memop, misaligned;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic [31:0] lbuf;
   logic [7:0]  lb;
   logic [15:0] lh;
   logic [31:0] load_data;
   logic [31:0] wb_data_nx;

   assign a = mem_alu_result[1:0];

   // A read request wins over a simultaneous write, so its size decides alignment.
   always_comb begin
      size = mem_mem_read ? mem_load_size : mem_store_size;
      case (size)
         2'b00:   aligned = 1'b1;
         2'b01:   aligned = ~a[0];
         2'b10:   aligned = (a == 2'b00);
         default: aligned = 1'b0;
      endcase
   end

   assign access     = mem_mem_read | mem_mem_write;
   assign memop      = access & aligned;
   assign misaligned = access & ~aligned;

   always_comb begin
      be    = 4'b1111;
      wdata = mem_rs2_val_for_store;
      case (size)
         2'b00: begin
            be    = 4'b0001 << a;
            wdata = {4{mem_rs2_val_for_store[7:0]}};
         end
         2'b01: begin
            be    = 4'b0011 << {a[1], 1'b0};
            wdata = {2{mem_rs2_val_for_store[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      lb = lbuf[{a, 3'b000} +: 8];
      lh = a[1] ? lbuf[31:16] : lbuf[15:0];
      case (mem_load_size)
         2'b00:   load_data = {{24{mem_load_signed & lb[7]}}, lb};
         2'b01:   load_data = {{16{mem_load_signed & lh[15]}}, lh};
         default: load_data = lbuf;
      endcase
   end

   always_comb begin
      case (mem_wb_sel)
         2'b00:   wb_data_nx = mem_alu_result;
         2'b01:   wb_data_nx = load_data;
         default: wb_data_nx = mem_wb_candidate;
      endcase
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (memop) state_nx = REQ;
         REQ:     if (dbus_gnt) state_nx = dbus_we ? DONE : RESP;
         RESP:    if (dbus_rvalid) state_nx = DONE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   assign stall_o  = ~rst & (((state == IDLE) & memop) | (state == REQ) | (state == RESP));
   assign dbus_req = (state == REQ);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dbus_we    <= 1'b0;
         dbus_addr  <= '0;
         dbus_be    <= '0;
         dbus_wdata <= '0;
         lbuf       <= '0;
      end else begin
         if (state == IDLE && memop) begin
            dbus_we    <= ~mem_mem_read;
            dbus_addr  <= {mem_alu_result[31:2], 2'b00};
            dbus_be    <= be;
            dbus_wdata <= wdata;
         end
         if (state == RESP && dbus_rvalid) lbuf <= dbus_rdata;
      end
   end

   // While stalled the register fills with an all-zero bubble.
   always_ff @(posedge clk or posedge rst) begin
      if (rst || stall_o) begin
         wb_pc         <= '0;
         wb_data       <= '0;
         wb_rd_addr    <= '0;
         wb_csr_addr   <= '0;
         wb_reg_write  <= 1'b0;
         wb_csr_hit    <= 1'b0;
         wb_ecall      <= 1'b0;
         wb_ebreak     <= 1'b0;
         wb_fence      <= 1'b0;
         wb_misaligned <= 1'b0;
         wb_bad_addr   <= '0;
      end else begin
         wb_pc         <= mem_pc;
         wb_data       <= wb_data_nx;
         wb_rd_addr    <= mem_rd_addr;
         wb_csr_addr   <= mem_csr_addr;
         wb_reg_write  <= mem_reg_write & ~misaligned;
         wb_csr_hit    <= mem_csr_hit;
         wb_ecall      <= mem_ecall;
         wb_ebreak     <= mem_ebreak;
         wb_fence      <= mem_fence;
         wb_misaligned <= misaligned;
         wb_bad_addr   <= misaligned ? mem_alu_result : 32'h0;
      end
   end
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: loads, stores, misaligned traps, pass-through and reset abort.
module tb_mem_stage;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] mem_pc, mem_alu_result, mem_rs2_val_for_store, mem_wb_candidate;
   logic [4:0]  mem_rd_addr;
   logic        mem_reg_write, mem_mem_read, mem_mem_write, mem_load_signed;
   logic        mem_csr_hit, mem_ecall, mem_ebreak, mem_fence;
   logic [1:0]  mem_wb_sel, mem_load_size, mem_store_size;
   logic [11:0] mem_csr_addr;
   logic        stall_o, dbus_req, dbus_we;
   logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
   logic [3:0]  dbus_be;
   logic        dbus_gnt, dbus_rvalid;
   logic [31:0] wb_pc, wb_data, wb_bad_addr;
   logic [4:0]  wb_rd_addr;
   logic [11:0] wb_csr_addr;
   logic        wb_reg_write, wb_csr_hit, wb_ecall, wb_ebreak, wb_fence, wb_misaligned;

   int checks = 0;
   int errors = 0;

   mem_stage dut (
      .clk(clk), .rst(rst),
      .mem_pc(mem_pc), .mem_alu_result(mem_alu_result),
      .mem_rs2_val_for_store(mem_rs2_val_for_store), .mem_wb_candidate(mem_wb_candidate),
      .mem_rd_addr(mem_rd_addr), .mem_reg_write(mem_reg_write),
      .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
      .mem_load_signed(mem_load_signed), .mem_csr_hit(mem_csr_hit),
      .mem_ecall(mem_ecall), .mem_ebreak(mem_ebreak), .mem_fence(mem_fence),
      .mem_wb_sel(mem_wb_sel), .mem_load_size(mem_load_size),
      .mem_store_size(mem_store_size), .mem_csr_addr(mem_csr_addr),
      .stall_o(stall_o), .dbus_req(dbus_req), .dbus_we(dbus_we),
      .dbus_addr(dbus_addr), .dbus_be(dbus_be), .dbus_wdata(dbus_wdata),
      .dbus_gnt(dbus_gnt), .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata),
      .wb_pc(wb_pc), .wb_data(wb_data), .wb_rd_addr(wb_rd_addr),
      .wb_csr_addr(wb_csr_addr), .wb_reg_write(wb_reg_write),
      .wb_csr_hit(wb_csr_hit), .wb_ecall(wb_ecall), .wb_ebreak(wb_ebreak),
      .wb_fence(wb_fence), .wb_misaligned(wb_misaligned), .wb_bad_addr(wb_bad_addr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic nop_in();
      mem_pc = 32'h0; mem_alu_result = 32'h0; mem_rs2_val_for_store = 32'h0;
      mem_wb_candidate = 32'h0; mem_rd_addr = 5'd0; mem_reg_write = 1'b0;
      mem_mem_read = 1'b0; mem_mem_write = 1'b0; mem_load_signed = 1'b0;
      mem_csr_hit = 1'b0; mem_ecall = 1'b0; mem_ebreak = 1'b0; mem_fence = 1'b0;
      mem_wb_sel = 2'd0; mem_load_size = 2'd2; mem_store_size = 2'd2; mem_csr_addr = 12'h0;
   endtask

   // Runs the memop already on the EX/MEM inputs; returns what was seen on the bus and the
   // MEM/WB contents after the capture edge. Inputs revert to a nop after DONE.
   task automatic mem_op(input bit is_load, input int gwait, input logic [31:0] rdata,
                         output int stalls, output int reqs, output logic [3:0] be,
                         output logic [31:0] wd, output logic we, output logic [31:0] addr,
                         output logic bubble_flags, output bit done);
      bit gave = 0;
      stalls = 0; reqs = 0; be = '0; wd = '0; we = 1'b0; addr = '0;
      bubble_flags = 1'b0; done = 0;
      for (int i = 0; i < 40; i++) begin
         #1;
         dbus_gnt = 1'b0; dbus_rvalid = 1'b0;
         if (!stall_o) begin done = 1; break; end
         stalls++;
         if (stalls >= 2)
            bubble_flags |= wb_reg_write | wb_csr_hit | wb_ecall | wb_ebreak | wb_fence | wb_misaligned;
         if (dbus_req) begin
            reqs++;
            be = dbus_be; wd = dbus_wdata; we = dbus_we; addr = dbus_addr;
            if (reqs == gwait + 1) begin dbus_gnt = 1'b1; gave = 1; end
         end else if (gave && is_load) begin
            dbus_rvalid = 1'b1; dbus_rdata = rdata;
         end
         @(posedge clk);
      end
      if (!done) begin
         errors++;
         $display("FAIL mem_op_timeout observed=stall_stuck expected=done");
      end
      cyc();
      nop_in();
   endtask

   int          st, rq;
   logic [3:0]  be_s;
   logic [31:0] wd_s, ad_s;
   logic        we_s, bub;
   bit          ok;

   task automatic setup_load(input logic [31:0] addr, input logic [1:0] sz, input logic sgn);
      nop_in();
      mem_pc = 32'h40; mem_alu_result = addr; mem_rd_addr = 5'd5; mem_reg_write = 1'b1;
      mem_mem_read = 1'b1; mem_load_size = sz; mem_load_signed = sgn; mem_wb_sel = 2'd1;
   endtask

   initial begin
      rst = 1'b1; dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_rdata = 32'h0;
      nop_in();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_wb_data", wb_data, 32'h0);
      chk("rst_wb_reg_write", {31'h0, wb_reg_write}, 32'h0);
      chk("rst_dbus_req", {31'h0, dbus_req}, 32'h0);
      chk("rst_dbus_be", {28'h0, dbus_be}, 32'h0);
      chk("rst_stall", {31'h0, stall_o}, 32'h0);
      rst = 1'b0;
      cyc();

      // LW 0x100, gnt on first REQ cycle, rvalid the next cycle
      setup_load(32'h100, 2'd2, 1'b0);
      mem_op(1, 0, 32'hDEADBEEF, st, rq, be_s, wd_s, we_s, ad_s, bub, ok);
      chk("lw_addr", ad_s, 32'h100);
      chk("lw_be", {28'h0, be_s}, 32'hF);
      chk("lw_we", {31'h0, we_s}, 32'h0);
      chk("lw_stalls", st, 3);
      chk("lw_wb_data", wb_data, 32'hDEADBEEF);
      chk("lw_wb_rw", {31'h0, wb_reg_write}, 32'h1);
      chk("lw_wb_rd", {27'h0, wb_rd_addr}, 32'd5);

      setup_load(32'h103, 2'd0, 1'b1);
      mem_op(1, 0, 32'h80FFFF7F, st, rq, be_s, wd_s, we_s, ad_s, bub, ok);
      chk("lb_be", {28'h0, be_s}, 32'h8);
      chk("lb_wb_data", wb_data, 32'hFFFFFF80);

      setup_load(32'h103, 2'd0, 1'b0);
      mem_op(1, 0, 32'h80FFFF7F, st, rq, be_s, wd_s, we_s, ad_s, bub, ok);
      chk("lbu_wb_data", wb_data, 32'h00000080);

      setup_load(32'h102, 2'd1, 1'b1);
      mem_op(1, 1, 32'h80FFFF7F, st, rq, be_s, wd_s, we_s, ad_s, bub, ok);
      chk("lh_be", {28'h0, be_s}, 32'hC);
      chk("lh_wb_data", wb_data, 32'hFFFF80FF);

      // SH 0x206 with gnt 3 cycles late; preceded by a reg-writing op so bubbles are visible
      mem_reg_write = 1'b1; mem_alu_result = 32'h77; mem_rd_addr = 5'd3;
      cyc();
      chk("pre_sh_rw", {31'h0, wb_reg_write}, 32'h1);
      nop_in();
      mem_mem_write = 1'b1; mem_store_size = 2'd1; mem_alu_result = 32'h206;
      mem_rs2_val_for_store = 32'h1234ABCD;
      mem_op(0, 3, 32'h0, st, rq, be_s, wd_s, we_s, ad_s, bub, ok);
      chk("sh_req_cycles", rq, 4);
      chk("sh_stalls", st, 5);
      chk("sh_addr", ad_s, 32'h204);
      chk("sh_be", {28'h0, be_s}, 32'hC);
      chk("sh_wdata", wd_s, 32'hABCDABCD);
      chk("sh_we", {31'h0, we_s}, 32'h1);
      chk("sh_bubbles", {31'h0, bub}, 32'h0);
      chk("sh_wb_rw", {31'h0, wb_reg_write}, 32'h0);

      mem_mem_write = 1'b1; mem_store_size = 2'd0; mem_alu_result = 32'h201;
      mem_rs2_val_for_store = 32'hFFFFFF5A;
      mem_op(0, 0, 32'h0, st, rq, be_s, wd_s, we_s, ad_s, bub, ok);
      chk("sb_be", {28'h0, be_s}, 32'h2);
      chk("sb_wdata", wd_s, 32'h5A5A5A5A);
      chk("sb_stalls", st, 2);

      // Misaligned LW: no bus, no stall, one-cycle trap record
      setup_load(32'h102, 2'd2, 1'b0);
      #1;
      chk("mis_stall", {31'h0, stall_o}, 32'h0);
      chk("mis_req", {31'h0, dbus_req}, 32'h0);
      cyc();
      chk("mis_flag", {31'h0, wb_misaligned}, 32'h1);
      chk("mis_bad_addr", wb_bad_addr, 32'h102);
      chk("mis_rw", {31'h0, wb_reg_write}, 32'h0);
      nop_in();
      chk("mis_req_after", {31'h0, dbus_req}, 32'h0);
      cyc();
      chk("mis_flag_clear", {31'h0, wb_misaligned}, 32'h0);

      // ADD then JAL pass straight through
      mem_reg_write = 1'b1; mem_wb_sel = 2'd0; mem_alu_result = 32'h55; mem_csr_addr = 12'h305;
      #1;
      chk("add_stall", {31'h0, stall_o}, 32'h0);
      cyc();
      chk("add_wb_data", wb_data, 32'h55);
      chk("add_csr_addr", {20'h0, wb_csr_addr}, 32'h305);
      mem_wb_sel = 2'd2; mem_wb_candidate = 32'h1004; mem_alu_result = 32'h2000; mem_pc = 32'h1000;
      #1;
      chk("jal_stall", {31'h0, stall_o}, 32'h0);
      cyc();
      chk("jal_wb_data", wb_data, 32'h1004);
      chk("jal_wb_pc", wb_pc, 32'h1000);

      // Reset while waiting in RESP
      setup_load(32'h300, 2'd2, 1'b0);
      cyc();
      chk("rr_req", {31'h0, dbus_req}, 32'h1);
      dbus_gnt = 1'b1;
      cyc();
      dbus_gnt = 1'b0;
      chk("rr_resp_stall", {31'h0, stall_o}, 32'h1);
      #2 rst = 1'b1;
      #1;
      chk("rr_stall", {31'h0, stall_o}, 32'h0);
      chk("rr_req_low", {31'h0, dbus_req}, 32'h0);
      chk("rr_wb_rw", {31'h0, wb_reg_write}, 32'h0);
      chk("rr_dbus_addr", dbus_addr, 32'h0);
      nop_in();
      cyc();
      rst = 1'b0;
      dbus_rvalid = 1'b1; dbus_rdata = 32'hCAFEBABE;
      cyc();
      dbus_rvalid = 1'b0;
      // a non-memory op selecting load data sees the cleared buffer
      mem_reg_write = 1'b1; mem_wb_sel = 2'd1; mem_load_size = 2'd2;
      #1;
      chk("rr_idle_stall", {31'h0, stall_o}, 32'h0);
      cyc();
      chk("rr_lbuf", wb_data, 32'h0);
      chk("rr_wb_rw_after", {31'h0, wb_reg_write}, 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
